// File: rtl/alu_issue.sv
// Issue stage for the ALU32FF: decodes one RV32IM reg/imm op, drives the one-hot
// control word and operands for the op's settle time, then returns the result.
module alu_issue #(
    parameter int MUL_WAIT = 2,
    parameter int DIV_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rd,
    output logic [15:0] alu_ctl,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_res,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam int CNT_W     = 16;
    localparam int MUL_W_EFF = (MUL_WAIT < 1) ? 1 : MUL_WAIT;
    localparam int DIV_W_EFF = (DIV_WAIT < 1) ? 1 : DIV_WAIT;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_W_EFF - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_W_EFF - 1);

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [15:0] C_ADD  = 16'h0001, C_SUB  = 16'h0002, C_MUL  = 16'h0004;
    localparam logic [15:0] C_DIV  = 16'h0008, C_REM  = 16'h0010, C_MULH = 16'h0020;
    localparam logic [15:0] C_SLT  = 16'h0040, C_SLTU = 16'h0080, C_SLL  = 16'h0100;
    localparam logic [15:0] C_SRL  = 16'h0200, C_SRA  = 16'h0400, C_AND  = 16'h0800;
    localparam logic [15:0] C_OR   = 16'h1000, C_XOR  = 16'h2000;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       ctl_q, ctl_d;
    logic [31:0]       op1_q, op1_d, op2_q, op2_d;
    logic [4:0]        rd_q, rd_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_res_q, out_res_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_illegal_q, out_illegal_d;

    logic [15:0]       dec_ctl;
    logic              dec_shift, dec_imm, dec_legal;
    logic [CNT_W-1:0]  dec_load;
    logic [31:0]       dec_op2_raw, dec_op2;

    // Anything not matched leaves dec_ctl at zero, which marks it illegal.
    always_comb begin
        dec_ctl   = '0;
        dec_shift = 1'b0;
        dec_imm   = 1'b0;
        dec_load  = '0;
        case (in_opcode)
            OP_R: begin
                case (in_funct7)
                    7'b0000000: begin
                        case (in_funct3)
                            3'b000: dec_ctl = C_ADD;
                            3'b001: begin dec_ctl = C_SLL; dec_shift = 1'b1; end
                            3'b010: dec_ctl = C_SLT;
                            3'b011: dec_ctl = C_SLTU;
                            3'b100: dec_ctl = C_XOR;
                            3'b101: begin dec_ctl = C_SRL; dec_shift = 1'b1; end
                            3'b110: dec_ctl = C_OR;
                            default: dec_ctl = C_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (in_funct3 == 3'b000) begin
                            dec_ctl = C_SUB;
                        end else if (in_funct3 == 3'b101) begin
                            dec_ctl   = C_SRA;
                            dec_shift = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        case (in_funct3)
                            3'b000: begin dec_ctl = C_MUL;  dec_load = MUL_LOAD; end
                            3'b001: begin dec_ctl = C_MULH; dec_load = MUL_LOAD; end
                            3'b101: begin dec_ctl = C_DIV;  dec_load = DIV_LOAD; end
                            3'b111: begin dec_ctl = C_REM;  dec_load = DIV_LOAD; end
                            default: dec_ctl = '0;
                        endcase
                    end
                    default: dec_ctl = '0;
                endcase
            end
            OP_I: begin
                dec_imm = 1'b1;
                case (in_funct3)
                    3'b000: dec_ctl = C_ADD;
                    3'b010: dec_ctl = C_SLT;
                    3'b011: dec_ctl = C_SLTU;
                    3'b100: dec_ctl = C_XOR;
                    3'b110: dec_ctl = C_OR;
                    3'b111: dec_ctl = C_AND;
                    3'b001: begin
                        if (in_funct7 == 7'b0000000) begin
                            dec_ctl   = C_SLL;
                            dec_shift = 1'b1;
                        end
                    end
                    default: begin
                        dec_shift = 1'b1;
                        if (in_funct7 == 7'b0000000) begin
                            dec_ctl = C_SRL;
                        end else if (in_funct7 == 7'b0100000) begin
                            dec_ctl = C_SRA;
                        end
                    end
                endcase
            end
            default: dec_ctl = '0;
        endcase
    end

    assign dec_legal   = |dec_ctl;
    assign dec_op2_raw = dec_imm ? in_imm : in_rs2;
    assign dec_op2     = dec_shift ? {27'b0, dec_op2_raw[4:0]} : dec_op2_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = dec_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        alu_ctl     = (state_q == EXEC) ? ctl_q : '0;
        alu_op1     = op1_q;
        alu_op2     = op2_q;
        out_valid   = out_valid_q;
        out_res     = out_res_q;
        out_rd      = out_rd_q;
        out_illegal = out_illegal_q;
    end

    always_comb begin
        cnt_d         = cnt_q;
        ctl_d         = ctl_q;
        op1_d         = op1_q;
        op2_d         = op2_q;
        rd_d          = rd_q;
        out_valid_d   = out_valid_q;
        out_res_d     = out_res_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        case (state_q)
            IDLE: begin
                if (in_valid && dec_legal) begin
                    ctl_d = dec_ctl;
                    op1_d = in_rs1;
                    op2_d = dec_op2;
                    rd_d  = in_rd;
                    cnt_d = dec_load;
                end else if (in_valid) begin
                    out_res_d     = '0;
                    out_illegal_d = 1'b1;
                    out_rd_d      = in_rd;
                    out_valid_d   = 1'b1;
                end
            end
            EXEC: begin
                // Operands have been stable for the full settle time when cnt reaches 0.
                if (cnt_q == '0) begin
                    out_res_d     = alu_res;
                    out_illegal_d = 1'b0;
                    out_rd_d      = rd_q;
                    out_valid_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            ctl_q         <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            rd_q          <= '0;
            out_valid_q   <= 1'b0;
            out_res_q     <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ctl_q         <= ctl_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            rd_q          <= rd_d;
            out_valid_q   <= out_valid_d;
            out_res_q     <= out_res_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU on the control/operand port, and an
// instruction-level reference model for the expected control word, timing and result.
module tb_alu_issue;

    localparam int MUL_WAIT = 2;
    localparam int DIV_WAIT = 4;
    localparam int MW = (MUL_WAIT < 1) ? 1 : MUL_WAIT;
    localparam int DW = (DIV_WAIT < 1) ? 1 : DIV_WAIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic [4:0]  in_rd;
    logic [15:0] alu_ctl;
    logic [31:0] alu_op1, alu_op2, alu_res;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_res;

    alu_issue #(.MUL_WAIT(MUL_WAIT), .DIV_WAIT(DIV_WAIT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_ctl(alu_ctl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // External combinational ALU driven by the one-hot control word.
    logic signed [63:0] alu_mulh;
    assign alu_mulh = $signed({{32{alu_op1[31]}}, alu_op1}) * $signed({{32{alu_op2[31]}}, alu_op2});

    always_comb begin
        alu_res = '0;
        case (alu_ctl)
            16'h0001: alu_res = alu_op1 + alu_op2;
            16'h0002: alu_res = alu_op1 - alu_op2;
            16'h0004: alu_res = alu_op1 * alu_op2;
            16'h0008: alu_res = (alu_op2 == 0) ? 32'hFFFF_FFFF : alu_op1 / alu_op2;
            16'h0010: alu_res = (alu_op2 == 0) ? alu_op1 : alu_op1 % alu_op2;
            16'h0020: alu_res = alu_mulh[63:32];
            16'h0040: alu_res = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
            16'h0080: alu_res = {31'b0, alu_op1 < alu_op2};
            16'h0100: alu_res = alu_op1 << alu_op2[4:0];
            16'h0200: alu_res = alu_op1 >> alu_op2[4:0];
            16'h0400: alu_res = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
            16'h0800: alu_res = alu_op1 & alu_op2;
            16'h1000: alu_res = alu_op1 | alu_op2;
            16'h2000: alu_res = alu_op1 ^ alu_op2;
            16'h4000: alu_res = ~alu_op1;
            default:  alu_res = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Instruction semantics: legality, control bit, settle time, operand 2 and result.
    function automatic void ref_model(
        input  logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
        input  logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
        output bit legal, output logic [15:0] ctl, output logic [31:0] res,
        output logic [31:0] op2, output int w);
        int bitn;
        int sh;
        logic [31:0] y;
        logic signed [63:0] p;
        bitn = -1;
        w    = 1;
        res  = '0;
        y    = (opc == 7'h13) ? imm : b;
        sh   = int'(y[4:0]);
        op2  = y;
        if (opc == 7'h33 && f7 == 7'h00) begin
            case (f3)
                3'd0: begin bitn = 0;  res = a + y; end
                3'd1: begin bitn = 8;  res = a << sh; end
                3'd2: begin bitn = 6;  res = ($signed(a) < $signed(y)) ? 1 : 0; end
                3'd3: begin bitn = 7;  res = (a < y) ? 1 : 0; end
                3'd4: begin bitn = 13; res = a ^ y; end
                3'd5: begin bitn = 9;  res = a >> sh; end
                3'd6: begin bitn = 12; res = a | y; end
                default: begin bitn = 11; res = a & y; end
            endcase
        end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
            bitn = 1; res = a - y;
        end else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd5) begin
            bitn = 10;
        end else if (opc == 7'h33 && f7 == 7'h01 && f3 == 3'd0) begin
            bitn = 2; w = MW; res = a * y;
        end else if (opc == 7'h33 && f7 == 7'h01 && f3 == 3'd1) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{y[31]}}, y});
            bitn = 5; w = MW; res = p[63:32];
        end else if (opc == 7'h33 && f7 == 7'h01 && f3 == 3'd5) begin
            bitn = 3; w = DW; res = (y == 0) ? 32'hFFFF_FFFF : a / y;
        end else if (opc == 7'h33 && f7 == 7'h01 && f3 == 3'd7) begin
            bitn = 4; w = DW; res = (y == 0) ? a : a % y;
        end else if (opc == 7'h13) begin
            case (f3)
                3'd0: begin bitn = 0;  res = a + y; end
                3'd2: begin bitn = 6;  res = ($signed(a) < $signed(y)) ? 1 : 0; end
                3'd3: begin bitn = 7;  res = (a < y) ? 1 : 0; end
                3'd4: begin bitn = 13; res = a ^ y; end
                3'd6: begin bitn = 12; res = a | y; end
                3'd7: begin bitn = 11; res = a & y; end
                3'd1: if (f7 == 7'h00) begin bitn = 8; res = a << sh; end
                default: begin
                    if (f7 == 7'h00) begin bitn = 9; res = a >> sh; end
                    else if (f7 == 7'h20) bitn = 10;
                end
            endcase
        end
        if (bitn == 10) begin
            res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        end
        if (bitn == 8 || bitn == 9 || bitn == 10) op2 = {27'b0, y[4:0]};
        legal = (bitn >= 0);
        ctl   = legal ? (16'h0001 << bitn) : 16'h0000;
        if (!legal) res = '0;
    endfunction

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                          input logic [4:0] rd, input int hold);
        bit legal;
        logic [15:0] ectl;
        logic [31:0] eres, eop2;
        int w;
        ref_model(opc, f3, f7, a, b, imm, legal, ectl, eres, eop2, w);
        for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("accept_ready", in_ready, 1);
        in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
        in_rs1 = a; in_rs2 = b; in_imm = imm; in_rd = rd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (legal) begin
            for (int i = 0; i < w; i++) begin
                chk("exec_ctl", alu_ctl, ectl);
                chk("exec_op1", alu_op1, a);
                chk("exec_op2", alu_op2, eop2);
                chk("exec_busy", {in_ready, out_valid}, 0);
                @(posedge clk); #1;
            end
        end
        chk("out_valid", out_valid, 1);
        chk("done_ctl", alu_ctl, 0);
        chk("out_res", out_res, eres);
        chk("out_rd", out_rd, rd);
        chk("out_illegal", out_illegal, !legal);
        chk("done_ready", in_ready, 0);
        last_res = out_res;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_opcode = 7'h33; in_funct3 = 3'd0; in_funct7 = 7'h00; in_rd = ~rd;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_res", out_res, eres);
            chk("hold_rd", out_rd, rd);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
        chk("idle_ctl", alu_ctl, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  r_opc, r_f7;
        logic [2:0]  r_f3;
        logic [31:0] r_a, r_b, r_imm;
        logic [11:0] r12;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_rd = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_ctl", alu_ctl, 0);
        chk("rst_op1", alu_op1, 0);
        chk("rst_op2", alu_op2, 0);
        chk("rst_res", out_res, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_illegal", out_illegal, 0);

        run_op(7'h13, 3'd0, 7'h00, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd7, 0);
        chk("addi_lit", last_res, 32'd2);
        run_op(7'h33, 3'd0, 7'h20, 32'd3, 32'd5, 32'd0, 5'd1, 5);
        chk("sub_lit", last_res, 32'hFFFF_FFFE);
        run_op(7'h33, 3'd2, 7'h00, 32'd3, 32'd5, 32'd0, 5'd2, 0);
        chk("slt_lit", last_res, 32'd1);
        run_op(7'h33, 3'd5, 7'h01, 32'd100, 32'd7, 32'd0, 5'd3, 1);
        chk("divu_lit", last_res, 32'd14);
        run_op(7'h33, 3'd7, 7'h01, 32'd100, 32'd7, 32'd0, 5'd4, 0);
        chk("remu_lit", last_res, 32'd2);
        run_op(7'h33, 3'd1, 7'h00, 32'd1, 32'h0000_0123, 32'd0, 5'd5, 0);
        chk("sll_lit", last_res, 32'd8);
        run_op(7'h33, 3'd4, 7'h01, 32'd100, 32'd7, 32'd0, 5'd6, 2);
        chk("sdiv_lit", last_res, 32'd0);
        run_op(7'h33, 3'd1, 7'h01, 32'h8000_0000, 32'h0000_0003, 32'd0, 5'd8, 0);
        run_op(7'h13, 3'd5, 7'h20, 32'hF000_0010, 32'd0, 32'h0000_0404, 5'd9, 0);
        run_op(7'h13, 3'd1, 7'h20, 32'd1, 32'd0, 32'h0000_0401, 5'd10, 0);
        run_op(7'h33, 3'd2, 7'h01, 32'd9, 32'd9, 32'd0, 5'd11, 0);

        // Reset in the middle of a multiply discards it.
        in_opcode = 7'h33; in_funct3 = 3'd0; in_funct7 = 7'h01;
        in_rs1 = 32'd6; in_rs2 = 32'd7; in_rd = 5'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mul_ctl", alu_ctl, 16'h0004);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ctl", alu_ctl, 0);
        chk("midrst_op1", alu_op1, 0);
        chk("midrst_op2", alu_op2, 0);
        chk("midrst_res", out_res, 0);
        chk("midrst_rd", out_rd, 0);
        chk("midrst_ready", in_ready, 1);
        for (int i = 0; i < MW + 2; i++) begin
            @(posedge clk); #1;
            chk("midrst_quiet", out_valid, 0);
        end

        for (int n = 0; n < 60; n++) begin
            r_opc = ($urandom_range(0, 5) == 0) ? 7'($urandom) :
                    (($urandom_range(0, 1) == 1) ? 7'h33 : 7'h13);
            r_f3  = 3'($urandom);
            case ($urandom_range(0, 3))
                0: r_f7 = 7'h00;
                1: r_f7 = 7'h20;
                2: r_f7 = 7'h01;
                default: r_f7 = 7'($urandom);
            endcase
            r_a   = $urandom;
            r_b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            if (r_b == 0) r_b = 32'd1;
            r12   = 12'($urandom);
            r_imm = {{20{r12[11]}}, r12};
            run_op(r_opc, r_f3, r_f7, r_a, r_b, r_imm, 5'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
